// File: rtl/udm_bus_arb.sv
// Two-master round-robin arbiter for the request/ack/resp bus. The grant is held
// while a read is outstanding, and a response timeout returns a synthetic error.
module udm_bus_arb #(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       RESP_TIMEOUT = 1024,
  parameter logic [DATA_W-1:0] ERR_RDATA    = 32'hDEADBEEF
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                m0_req_i,
  input  logic                m0_we_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W/8-1:0] m0_be_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  output logic                m0_ack_o,
  output logic                m0_resp_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W/8-1:0] m1_be_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  output logic                m1_ack_o,
  output logic                m1_resp_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                s_req_o,
  output logic                s_we_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W/8-1:0] s_be_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  input  logic                s_ack_i,
  input  logic                s_resp_i,
  input  logic [DATA_W-1:0]   s_rdata_i,
  output logic                timeout_o,
  output logic                stray_resp_o
);

  localparam int unsigned      BE_W     = DATA_W / 8;
  localparam int unsigned      TMO_W    = $clog2(RESP_TIMEOUT) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RESP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    WAIT_RESP
  } state_e;

  state_e           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  logic              gnt_req;
  logic              gnt_we;
  logic [ADDR_W-1:0] gnt_addr;
  logic [BE_W-1:0]   gnt_be;
  logic [DATA_W-1:0] gnt_wdata;
  logic              resp_c;
  logic [DATA_W-1:0] rdata_c;

  // Request fields of the currently granted master
  assign gnt_req   = gnt_q ? m1_req_i   : m0_req_i;
  assign gnt_we    = gnt_q ? m1_we_i    : m0_we_i;
  assign gnt_addr  = gnt_q ? m1_addr_i  : m0_addr_i;
  assign gnt_be    = gnt_q ? m1_be_i    : m0_be_i;
  assign gnt_wdata = gnt_q ? m1_wdata_i : m0_wdata_i;

  // last_q resets to m1 so that m0 wins the first tie
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_d       = last_q;
    tmo_cnt_d    = tmo_cnt_q;
    s_req_o      = 1'b0;
    s_we_o       = 1'b0;
    s_addr_o     = '0;
    s_be_o       = '0;
    s_wdata_o    = '0;
    m0_ack_o     = 1'b0;
    m1_ack_o     = 1'b0;
    resp_c       = 1'b0;
    rdata_c      = '0;
    timeout_o    = 1'b0;
    stray_resp_o = 1'b0;

    case (state_q)
      IDLE: begin
        stray_resp_o = s_resp_i;
        if (m0_req_i || m1_req_i) begin
          gnt_d   = (m0_req_i && m1_req_i) ? ~last_q : m1_req_i;
          state_d = GRANT;
        end
      end
      GRANT: begin
        stray_resp_o = s_resp_i;
        s_req_o      = gnt_req;
        s_we_o       = gnt_we;
        s_addr_o     = gnt_addr;
        s_be_o       = gnt_be;
        s_wdata_o    = gnt_wdata;
        m0_ack_o     = s_ack_i & ~gnt_q;
        m1_ack_o     = s_ack_i & gnt_q;
        if (s_ack_i) begin
          last_d = gnt_q;
          if (gnt_we) begin
            state_d = IDLE;
          end else begin
            tmo_cnt_d = '0;
            state_d   = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        // A real response beats a timeout landing in the same cycle
        if (s_resp_i) begin
          resp_c  = 1'b1;
          rdata_c = s_rdata_i;
          state_d = IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          resp_c    = 1'b1;
          rdata_c   = ERR_RDATA;
          timeout_o = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    m0_resp_o  = resp_c & ~gnt_q;
    m1_resp_o  = resp_c & gnt_q;
    m0_rdata_o = m0_resp_o ? rdata_c : '0;
    m1_rdata_o = m1_resp_o ? rdata_c : '0;
  end

endmodule

// File: doc/udm_bus_arb.md
# udm_bus_arb

Two-master, one-slave arbiter for the on-chip request/ack/resp bus. It shares the bus between the UDM debug master (port m0) and a second master such as a CPU data port (port m1), in front of the SoC address decoder. It uses round-robin arbitration and keeps the grant locked while a read is outstanding. A response timeout keeps a master from hanging on a dead slave.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RESP_TIMEOUT, 1024, cycles to wait for a read response before a synthetic error response is returned; must be ≥2
- ERR_RDATA, 32'hDEADBEEF, rdata returned on timeout

Ports:
- clk_i  in  1  single system clock, all logic on rising edge
- rstn_i  in  1  synchronous, active-low reset
- mX_req_i  in  1  request from master X (X=0,1), held until mX_ack_o
- mX_we_i  in  1  1=write, 0=read
- mX_addr_i  in  ADDR_W  byte address
- mX_be_i  in  DATA_W/8  byte enables
- mX_wdata_i  in  DATA_W  write data
- mX_ack_o  out  1  request accepted, 1-cycle pulse
- mX_resp_o  out  1  read data valid, 1-cycle pulse
- mX_rdata_o  out  DATA_W  read data, valid with mX_resp_o
- s_req_o, s_we_o, s_addr_o, s_be_o, s_wdata_o  out  1/1/ADDR_W/DATA_W/8/DATA_W  forwarded request
- s_ack_i  in  1  slave accepted request
- s_resp_i  in  1  slave read response pulse
- s_rdata_i  in  DATA_W  slave read data
- timeout_o  out  1  1-cycle pulse when a read times out
- stray_resp_o  out  1  1-cycle pulse when s_resp_i arrives with no read outstanding

## Operation
- State FSM has three states: IDLE, GRANT, WAIT_RESP.
- Registers:
  - gnt: grant, 1 bit.
  - last: last granted master.
  - tmo_cnt: timeout counter, $clog2(RESP_TIMEOUT)+1 bits.
- IDLE:
  - If exactly one mX_req_i=1, set gnt=X and go to GRANT.
  - If both requests are 1, set gnt=~last and go to GRANT.
  - If neither is 1, stay in IDLE.
- GRANT:
  - s_* are driven combinationally from the granted master's inputs.
  - mX_ack_o = s_ack_i & (gnt==X).
  - On s_ack_i, set last=gnt.
    - If the request was a write, go to IDLE.
    - If it was a read, clear tmo_cnt and go to WAIT_RESP.
- WAIT_RESP:
  - s_req_o=0 and tmo_cnt increments every cycle.
  - On s_resp_i, forward it as mgnt_resp_o with mgnt_rdata_o=s_rdata_i (combinational), then go to IDLE.
  - When tmo_cnt==RESP_TIMEOUT-1 and s_resp_i=0:
    - pulse mgnt_resp_o with rdata=ERR_RDATA, plus timeout_o;
    - go to IDLE.
  - s_resp_i and the timeout in the same cycle: the real response wins and timeout_o stays 0.
- s_resp_i seen in IDLE or GRANT: ignored for the masters; stray_resp_o pulses.
- The non-granted master sees ack=0 and resp=0, and its request stays pending.
- Arbitration is work-conserving: no master starves, and under continuous contention grants alternate m0, m1, m0, ...

## Timing
- Reset values:
  - state=IDLE, gnt=0, last=1 (m0 wins the first tie), tmo_cnt=0.
  - All outputs are 0 (s_*, mX_ack_o, mX_resp_o, mX_rdata_o, timeout_o, stray_resp_o).
- Reset asserted mid-transaction: the FSM goes to IDLE on the next edge. The outstanding read is abandoned, and a later s_resp_i only raises stray_resp_o.
- Request latency:
  - mX_req_i rises at cycle n; s_req_o=1 at cycle n+1 (one registered arbitration cycle).
  - Earliest ack is cycle n+1 if the slave acks immediately.
- Write turnaround: the ack at cycle k leads to IDLE at k+1. The next grant is visible at k+2, so back-to-back writes cost 2 cycles each with a zero-wait slave.
- Read: ack at k, WAIT_RESP from k+1. A resp at cycle r appears on mX_resp_o in cycle r (no added latency) and the FSM is in IDLE at r+1.
- Timeout: with no resp, the error response fires at cycle k+RESP_TIMEOUT.
- mX_rdata_o is 0 whenever mX_resp_o=0.

## Test plan
- Single write from m0: addr 0x10000000, wdata 10, s_ack_i on the first cycle.
  - s_req_o is high for exactly 1 cycle with matching fields.
  - m0_ack_o pulses once; m1 outputs stay 0.
- Single read from m1: addr 0x20000000, slave responds 5 cycles after ack with 0xFEFE8800.
  - m1_resp_o pulses once with rdata 0xFEFE8800.
  - The FSM is back in IDLE the next cycle.
- Both masters assert write requests continuously for 6 transactions.
  - Grant order is m0, m1, m0, m1, m0, m1.
  - Each master receives exactly 3 acks.
- m0 read with the slave never responding, RESP_TIMEOUT=16.
  - m0_resp_o with rdata 0xDEADBEEF and timeout_o both pulse exactly 16 cycles after ack.
  - A pending m1 request is then granted.
- s_resp_i coincident with the timeout cycle.
  - Real rdata is delivered; timeout_o=0.
- Reset mid-read, then s_resp_i pulse.
  - All outputs are 0 after reset.
  - stray_resp_o=1 for the resp pulse; no mX_resp_o.
  - The first tie after reset is granted to m0.
